// File: rtl/sram_arb_pkg.sv
// Shared definitions for the fetch/data SRAM port arbiter.
package sram_arb_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_order_fifo.sv
// 1-bit requester-ID FIFO recording the order of accepted requests.
// Indices wrap modulo DEPTH; a separate wrap bit per side tells full from empty.
module arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] slots;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             wr_wrap;
  logic             rd_wrap;

  assign full  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
  assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
  assign head  = slots[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      slots   <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      wr_wrap <= 1'b0;
      rd_wrap <= 1'b0;
    end else begin
      if (push && !full) begin
        slots[wr_idx] <= din;
        if (wr_idx == AW'(DEPTH - 1)) begin
          wr_idx  <= '0;
          wr_wrap <= ~wr_wrap;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (pop && !empty) begin
        if (rd_idx == AW'(DEPTH - 1)) begin
          rd_idx  <= '0;
          rd_wrap <= ~rd_wrap;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters: data priority with
// anti-starvation, selection locked while memory stalls, responses routed in order.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ok
);

  localparam int SW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          win_data;
  logic          win_req;
  logic          accept;
  logic          resp_ok;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    win_data  = 1'b0;
    state_nxt = state;
    case (state)
      LOCK_I:  win_data = 1'b0;
      LOCK_D:  win_data = 1'b1;
      default: win_data = data_req && !((starve_cnt == SW'(STARVE_MAX)) && inst_req);
    endcase
    win_req = win_data ? data_req : inst_req;
    mem_req = win_req && !fifo_full && !reset;
    accept  = mem_req && mem_addr_ok;
    // Freeze the choice once memory has seen a request it has not yet taken.
    if (accept)                        state_nxt = IDLE;
    else if (state == IDLE && mem_req) state_nxt = win_data ? LOCK_D : LOCK_I;
  end

  always_ff @(posedge clk) begin
    if (reset || !inst_req)                                      starve_cnt <= '0;
    else if (accept && !win_data)                                starve_cnt <= '0;
    else if (accept && win_data && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign mem_wr    = !reset && win_data && data_wr;
  assign mem_wstrb = (!reset && win_data) ? data_wstrb : 4'h0;
  assign mem_wdata = (!reset && win_data) ? data_wdata : 32'h0;
  assign mem_addr  = reset ? 32'h0 : (win_data ? data_addr : inst_addr);

  assign inst_addr_ok = accept && !win_data;
  assign data_addr_ok = accept && win_data;

  assign resp_ok      = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = resp_ok && (fifo_head == ID_INST);
  assign data_data_ok = resp_ok && (fifo_head == ID_DATA);
  assign inst_rdata   = reset ? 32'h0 : mem_rdata;
  assign data_rdata   = reset ? 32'h0 : mem_rdata;

  arb_order_fifo #(.DEPTH(OUTSTANDING)) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (win_data ? ID_DATA : ID_INST),
    .pop   (resp_ok),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
